// File: rtl/cu_pkg.sv
// Shared definitions for the accumulator-CPU control unit: widths, opcodes,
// FSM state encoding, mux select codes and the decoded control word.
package cu_pkg;

    localparam int unsigned PC_W   = 6;  // program address width (64-word RAM)
    localparam int unsigned RA_W   = 3;  // general-register address width
    localparam int unsigned OP_W   = 4;  // opcode width, IR[15:12]
    localparam int unsigned ASEL_W = 2;  // accumulator input mux select width

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDR  = 4'h1;
    localparam logic [OP_W-1:0] OP_LDA  = 4'h4;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h5;
    localparam logic [OP_W-1:0] OP_STA  = 4'h6;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h7;
    localparam logic [OP_W-1:0] OP_JMP  = 4'h8;
    localparam logic [OP_W-1:0] OP_JZ   = 4'h9;
    localparam logic [OP_W-1:0] OP_JPOS = 4'hA;
    localparam logic [OP_W-1:0] OP_STR  = 4'hE;
    localparam logic [OP_W-1:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_FETCH_W = 3'd2,
        ST_DECODE  = 3'd3,
        ST_EXEC    = 3'd4,
        ST_HALT    = 3'd5
    } state_e;

    localparam logic [ASEL_W-1:0] ASEL_MEM = 2'd0;
    localparam logic [ASEL_W-1:0] ASEL_REG = 2'd1;
    localparam logic [ASEL_W-1:0] ASEL_ALU = 2'd2;

    localparam logic PC_SEL_INC  = 1'b0;
    localparam logic PC_SEL_IR   = 1'b1;
    localparam logic ADDR_SEL_PC = 1'b0;
    localparam logic ADDR_SEL_IR = 1'b1;

    // Per-opcode control word; the FSM decides in which state each bit acts.
    typedef struct packed {
        logic              legal;
        logic              mem_rd;
        logic              mem_wr;
        logic              reg_wr;
        logic              jmp;
        logic              jz;
        logic              jpos;
        logic              halt;
        logic              exec;    // needs an EXEC cycle to load A
        logic [ASEL_W-1:0] a_sel;
        logic              sub;
    } ctrl_t;

endpackage

// File: rtl/cu_if.sv
// Control-unit <-> datapath bundle.
//   master (control unit): drives strobes/selects, reads IR high byte and A flags.
//   slave  (datapath):     the reverse.
interface cu_if;
    logic [2*cu_pkg::OP_W-1:0]   ir158;
    logic                        apos;
    logic                        aeq0;
    logic                        clear;
    logic                        ir_load;
    logic                        pc_load;
    logic                        pc_sel;
    logic                        addr_sel;
    logic                        mem_we;
    logic                        reg_we;
    logic                        a_load;
    logic [cu_pkg::ASEL_W-1:0]   a_sel;
    logic                        sub;
    logic                        instr_done;
    logic                        halted;
    logic                        illegal;

    modport master (
        input  ir158, apos, aeq0,
        output clear, ir_load, pc_load, pc_sel, addr_sel, mem_we, reg_we,
               a_load, a_sel, sub, instr_done, halted, illegal
    );

    modport slave (
        output ir158, apos, aeq0,
        input  clear, ir_load, pc_load, pc_sel, addr_sel, mem_we, reg_we,
               a_load, a_sel, sub, instr_done, halted, illegal
    );
endinterface

// File: rtl/cu_decode.sv
// Combinational opcode -> control-word lookup.
//   op     : opcode from IR[15:12]
//   ctrl_c : decoded control word (legal=0 for undefined opcodes, else NOP-like)
module cu_decode
    import cu_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl_c
);

    always_comb begin
        ctrl_c       = '0;
        ctrl_c.legal = 1'b1;
        case (op)
            OP_NOP:  ;
            OP_LDR:  begin ctrl_c.exec = 1'b1; ctrl_c.a_sel = ASEL_REG; end
            OP_LDA:  begin ctrl_c.mem_rd = 1'b1; ctrl_c.exec = 1'b1; ctrl_c.a_sel = ASEL_MEM; end
            OP_ADD:  begin ctrl_c.mem_rd = 1'b1; ctrl_c.exec = 1'b1; ctrl_c.a_sel = ASEL_ALU; end
            OP_SUB:  begin
                ctrl_c.mem_rd = 1'b1;
                ctrl_c.exec   = 1'b1;
                ctrl_c.a_sel  = ASEL_ALU;
                ctrl_c.sub    = 1'b1;
            end
            OP_STA:  ctrl_c.mem_wr = 1'b1;
            OP_STR:  ctrl_c.reg_wr = 1'b1;
            OP_JMP:  ctrl_c.jmp    = 1'b1;
            OP_JZ:   ctrl_c.jz     = 1'b1;
            OP_JPOS: ctrl_c.jpos   = 1'b1;
            OP_HALT: ctrl_c.halt   = 1'b1;
            default: ctrl_c.legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/cu_fsm.sv
// Control unit FSM for the accumulator CPU: INIT -> FETCH -> FETCH_W -> DECODE
// [-> EXEC] -> FETCH, plus a terminal HALT left only through reset_n.
//   clk, reset_n : clock, asynchronous active-low reset
//   step         : (only with CU_SINGLE_STEP_EN) FETCH waits until step is high
//   bus          : cu_if.master -- IR high byte and A flags in; strobes, selects,
//                  instr_done, halted and the sticky illegal flag out
// Strobes are decoded from the registered state and ir158/A-flags only, so
// nothing depends combinationally on memory read data.
module cu_fsm
    import cu_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
`ifdef CU_SINGLE_STEP_EN
    input  logic  step,
`endif
    cu_if.master  bus
);

    state_e          state_q, state_d;
    logic            illegal_q, illegal_d;
    ctrl_t           ctrl_c;
    logic [OP_W-1:0] op_c;
    logic            step_ok_c;
    logic            jump_c;
    logic [RA_W:0]   unused_ir_lo;

    assign op_c         = bus.ir158[2*OP_W-1:OP_W];
    // Register index and bit 3 are consumed by the register file, not here.
    assign unused_ir_lo = bus.ir158[RA_W:0];

`ifdef CU_SINGLE_STEP_EN
    assign step_ok_c = step;
`else
    assign step_ok_c = 1'b1;
`endif

    cu_decode u_decode (
        .op     (op_c),
        .ctrl_c (ctrl_c)
    );

    // Flags come from A as left by the previous instruction.
    assign jump_c = ctrl_c.jmp | (ctrl_c.jz & bus.aeq0) | (ctrl_c.jpos & bus.apos);

    // State and sticky illegal flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_INIT;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_INIT:    state_d = ST_FETCH;
            ST_FETCH:   if (step_ok_c) state_d = ST_FETCH_W;
            ST_FETCH_W: state_d = ST_DECODE;
            ST_DECODE: begin
                if (!ctrl_c.legal) illegal_d = 1'b1;
                if (ctrl_c.halt)      state_d = ST_HALT;
                else if (ctrl_c.exec) state_d = ST_EXEC;
                else                  state_d = ST_FETCH;
            end
            ST_EXEC:    state_d = ST_FETCH;
            ST_HALT:    state_d = ST_HALT;
            default:    state_d = ST_INIT;
        endcase
    end

    // Outputs
    always_comb begin
        bus.clear      = 1'b0;
        bus.ir_load    = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_sel     = PC_SEL_INC;
        bus.addr_sel   = ADDR_SEL_PC;
        bus.mem_we     = 1'b0;
        bus.reg_we     = 1'b0;
        bus.a_load     = 1'b0;
        bus.a_sel      = ASEL_MEM;
        bus.sub        = 1'b0;
        bus.instr_done = 1'b0;
        bus.halted     = 1'b0;
        case (state_q)
            ST_INIT:  bus.clear = 1'b1;
            ST_FETCH: ;  // RAM captures M[PC] with addr_sel=PC, we=0
            ST_FETCH_W: begin
                bus.ir_load = 1'b1;
                bus.pc_load = 1'b1;
                bus.pc_sel  = PC_SEL_INC;
            end
            ST_DECODE: begin
                if (ctrl_c.mem_rd || ctrl_c.mem_wr) bus.addr_sel = ADDR_SEL_IR;
                bus.mem_we = ctrl_c.mem_wr;
                bus.reg_we = ctrl_c.reg_wr;
                if (jump_c) begin
                    bus.pc_load = 1'b1;
                    bus.pc_sel  = PC_SEL_IR;
                end
                bus.instr_done = !ctrl_c.exec;
            end
            ST_EXEC: begin
                // Hold the RAM address so qout stays valid while A loads
                if (ctrl_c.mem_rd) bus.addr_sel = ADDR_SEL_IR;
                bus.a_load     = 1'b1;
                bus.a_sel      = ctrl_c.a_sel;
                bus.sub        = ctrl_c.sub;
                bus.instr_done = 1'b1;
            end
            ST_HALT:  bus.halted = 1'b1;
            default:  ;
        endcase
    end

    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: each instruction pushes its expected per-cycle
// output vectors (with the inputs for that cycle); each test drains and checks.
module tb_cu_fsm;
    import cu_pkg::*;

    typedef struct packed {
        logic       clear;
        logic       ir_load;
        logic       pc_load;
        logic       pc_sel;
        logic       addr_sel;
        logic       mem_we;
        logic       reg_we;
        logic       a_load;
        logic [1:0] a_sel;
        logic       sub;
        logic       instr_done;
        logic       halted;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic [7:0] ir;
        logic       ap;
        logic       az;
        obs_t       exp;
        int         tag;
    } entry_t;

    logic clk = 1'b0;
    logic reset_n;
    cu_if bus();
`ifdef CU_SINGLE_STEP_EN
    logic step = 1'b1;
`endif

    cu_fsm dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef CU_SINGLE_STEP_EN
        .step    (step),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    entry_t sb_q[$];
    int     total = 0;
    int     bad   = 0;
    int     tag_n = 0;
    logic   exp_ill = 1'b0;

    function automatic obs_t sample();
        obs_t o;
        o.clear = bus.clear;   o.ir_load = bus.ir_load; o.pc_load = bus.pc_load;
        o.pc_sel = bus.pc_sel; o.addr_sel = bus.addr_sel; o.mem_we = bus.mem_we;
        o.reg_we = bus.reg_we; o.a_load = bus.a_load;   o.a_sel = bus.a_sel;
        o.sub = bus.sub;       o.instr_done = bus.instr_done;
        o.halted = bus.halted; o.illegal = bus.illegal;
        return o;
    endfunction

    function automatic obs_t idle_v();
        obs_t o = '0;
        o.illegal = exp_ill;
        return o;
    endfunction

    task automatic push(input logic [7:0] ir, input logic ap, input logic az, input obs_t e);
        entry_t x;
        x.ir = ir; x.ap = ap; x.az = az; x.exp = e; x.tag = tag_n;
        sb_q.push_back(x);
    endtask

    // Reference behaviour of one instruction, written from the opcode table.
    task automatic push_instr(input logic [7:0] ir, input logic ap, input logic az);
        obs_t       v;
        logic [3:0] op     = ir[7:4];
        logic       long_i = 1'b0;
        tag_n++;
        v = idle_v();                                   push(ir, ap, az, v);  // FETCH
        v = idle_v(); v.ir_load = 1'b1; v.pc_load = 1'b1; push(ir, ap, az, v);  // FETCH_W
        v = idle_v();                                                         // DECODE
        case (op)
            4'h0: v.instr_done = 1'b1;
            4'h1: long_i = 1'b1;
            4'h4, 4'h5, 4'h7: begin v.addr_sel = 1'b1; long_i = 1'b1; end
            4'h6: begin v.addr_sel = 1'b1; v.mem_we = 1'b1; v.instr_done = 1'b1; end
            4'hE: begin v.reg_we = 1'b1; v.instr_done = 1'b1; end
            4'h8: begin v.pc_load = 1'b1; v.pc_sel = 1'b1; v.instr_done = 1'b1; end
            4'h9: begin v.pc_load = az; v.pc_sel = az; v.instr_done = 1'b1; end
            4'hA: begin v.pc_load = ap; v.pc_sel = ap; v.instr_done = 1'b1; end
            default: v.instr_done = 1'b1;  // HALT and undefined opcodes
        endcase
        push(ir, ap, az, v);
        if (op == 4'h2 || op == 4'h3 || op == 4'hB || op == 4'hC || op == 4'hD)
            exp_ill = 1'b1;
        if (long_i) begin                                                     // EXEC
            v = idle_v(); v.a_load = 1'b1; v.instr_done = 1'b1;
            case (op)
                4'h1: v.a_sel = 2'd1;
                4'h4: begin v.a_sel = 2'd0; v.addr_sel = 1'b1; end
                4'h5: begin v.a_sel = 2'd2; v.addr_sel = 1'b1; end
                default: begin v.a_sel = 2'd2; v.sub = 1'b1; v.addr_sel = 1'b1; end
            endcase
            push(ir, ap, az, v);
        end
    endtask

    task automatic test_reset();
        obs_t got, want;
        reset_n = 1'b0; bus.ir158 = 8'h00; bus.apos = 1'b0; bus.aeq0 = 1'b0;
        exp_ill = 1'b0;
        want = '0; want.clear = 1'b1;
        repeat (3) begin
            @(negedge clk);
            got = sample(); total++;
            if (got !== want) begin bad++; $display("FAIL reset_hold got=%h want=%h", got, want); end
        end
        reset_n = 1'b1;
        #1;
        got = sample(); total++;
        if (got !== want) begin bad++; $display("FAIL reset_release got=%h want=%h", got, want); end
    endtask

    task automatic test_load_alu();
        entry_t e; obs_t got;
        push_instr(8'h40, 1'b0, 1'b1);
        push_instr(8'h70, 1'b1, 1'b0);
        push_instr(8'h50, 1'b0, 1'b0);
        push_instr(8'h15, 1'b1, 1'b1);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            bus.ir158 = e.ir; bus.apos = e.ap; bus.aeq0 = e.az;
            @(negedge clk);
            got = sample(); total++;
            if (got !== e.exp) begin bad++; $display("FAIL load_alu tag=%0d got=%h want=%h", e.tag, got, e.exp); end
        end
    endtask

    task automatic test_jumps();
        entry_t e; obs_t got;
        push_instr(8'h90, 1'b0, 1'b1);
        push_instr(8'h90, 1'b1, 1'b0);
        push_instr(8'hA3, 1'b1, 1'b0);
        push_instr(8'hA3, 1'b0, 1'b1);
        push_instr(8'h8F, 1'b0, 1'b0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            bus.ir158 = e.ir; bus.apos = e.ap; bus.aeq0 = e.az;
            @(negedge clk);
            got = sample(); total++;
            if (got !== e.exp) begin bad++; $display("FAIL jumps tag=%0d got=%h want=%h", e.tag, got, e.exp); end
        end
    endtask

    task automatic test_stores();
        entry_t e; obs_t got;
        push_instr(8'h60, 1'b0, 1'b0);
        push_instr(8'hE3, 1'b1, 1'b0);
        push_instr(8'h00, 1'b1, 1'b1);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            bus.ir158 = e.ir; bus.apos = e.ap; bus.aeq0 = e.az;
            @(negedge clk);
            got = sample(); total++;
            if (got !== e.exp) begin bad++; $display("FAIL stores tag=%0d got=%h want=%h", e.tag, got, e.exp); end
        end
    endtask

    task automatic test_back_to_back();
        entry_t e; obs_t got;
        logic [3:0] ops [10] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hE};
        for (int i = 0; i < 24; i++)
            push_instr({ops[$urandom_range(0, 9)], 4'($urandom_range(0, 15))},
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            bus.ir158 = e.ir; bus.apos = e.ap; bus.aeq0 = e.az;
            @(negedge clk);
            got = sample(); total++;
            if (got !== e.exp) begin bad++; $display("FAIL back_to_back tag=%0d got=%h want=%h", e.tag, got, e.exp); end
        end
    endtask

    task automatic test_illegal();
        entry_t e; obs_t got;
        push_instr(8'h20, 1'b0, 1'b0);
        push_instr(8'h00, 1'b0, 1'b0);
        push_instr(8'hB7, 1'b1, 1'b1);
        push_instr(8'h44, 1'b0, 1'b0);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            bus.ir158 = e.ir; bus.apos = e.ap; bus.aeq0 = e.az;
            @(negedge clk);
            got = sample(); total++;
            if (got !== e.exp) begin bad++; $display("FAIL illegal tag=%0d got=%h want=%h", e.tag, got, e.exp); end
        end
    endtask

    task automatic test_reset_mid_exec();
        entry_t e; obs_t got, want;
        want = '0; want.clear = 1'b1;
        // Abort an ADD in EXEC, then an STA while its write strobe is up.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) push_instr(8'h5A, 1'b0, 1'b0);
            else        push_instr(8'h61, 1'b0, 1'b0);
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                @(posedge clk); #1;
                bus.ir158 = e.ir; bus.apos = e.ap; bus.aeq0 = e.az;
                @(negedge clk);
                got = sample(); total++;
                if (got !== e.exp) begin bad++; $display("FAIL mid_reset_pre tag=%0d got=%h want=%h", e.tag, got, e.exp); end
            end
            #2 reset_n = 1'b0;
            #1;
            exp_ill = 1'b0;
            got = sample(); total++;
            if (got !== want) begin bad++; $display("FAIL mid_reset_async k=%0d got=%h want=%h", k, got, want); end
            @(negedge clk);
            reset_n = 1'b1;
            #1;
            got = sample(); total++;
            if (got !== want) begin bad++; $display("FAIL mid_reset_init k=%0d got=%h want=%h", k, got, want); end
        end
    endtask

    task automatic test_halt();
        entry_t e; obs_t got, hv;
        push_instr(8'hF2, 1'b0, 1'b0);
        hv = idle_v(); hv.halted = 1'b1;
        for (int i = 0; i < 20; i++)
            push(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), hv);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(posedge clk); #1;
            bus.ir158 = e.ir; bus.apos = e.ap; bus.aeq0 = e.az;
            @(negedge clk);
            got = sample(); total++;
            if (got !== e.exp) begin bad++; $display("FAIL halt tag=%0d got=%h want=%h", e.tag, got, e.exp); end
        end
    endtask

    initial begin
        test_reset();
        test_load_alu();
        test_jumps();
        test_stores();
        test_back_to_back();
        test_illegal();
        test_reset_mid_exec();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
